// File: rtl/cp0_vec.sv
// cp0_vec: coprocessor-0 style exception vectoring block.
//   Latches rising edges on expsrc into per-source pending bits. When the
//   global enable is set, it takes the lowest unmasked pending source. It
//   saves the PC into EPC and redirects pc_out to the handler vector for one
//   cycle. eret returns to IDLE and restores IE from PIE.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   inst                 instruction (inst[12:11] register select, inst[5:0] eret opcode)
//   pc_in, d_in          current PC, register write data
//   expsrc               exception request lines (one per source)
//   enable               register write strobe
//   exregwrite           write accepted this cycle
//   iseret               inst decodes as eret
//   hasexp               one-cycle pulse after an exception is taken
//   expblock             some pending source is masked
//   pc_out               redirect target (vector while hasexp, else EPC)
//   d_out                register read data
module cp0_vec #(
  parameter int unsigned NUM_SRC    = 8,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0180,
  parameter int unsigned VEC_STRIDE = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        inst,
  input  logic [31:0]        pc_in,
  input  logic [31:0]        d_in,
  input  logic [NUM_SRC-1:0] expsrc,
  input  logic               enable,
  output logic               exregwrite,
  output logic               iseret,
  output logic               hasexp,
  output logic               expblock,
  output logic [31:0]        pc_out,
  output logic [31:0]        d_out
);

  typedef enum logic {IDLE, SERVICE} state_t;

  state_t             state_q;
  logic [31:0]        epc_q;
  logic               ie_q;
  logic               pie_q;
  logic [NUM_SRC-1:0] block_q;
  logic [NUM_SRC-1:0] pend_q;
  logic [NUM_SRC-1:0] pend_d;
  logic [NUM_SRC-1:0] exp_q;
  logic [3:0]         cause_q;
  logic               hasexp_q;

  logic [1:0]         sel;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] cand;
  logic [NUM_SRC-1:0] take_mask;
  logic [3:0]         idx;
  logic               take;
  logic [31:0]        cause_rd;
  logic               unused_inst;

  assign sel         = inst[12:11];
  assign unused_inst = ^{inst[31:13], inst[10:6]};

  assign rise  = expsrc & ~exp_q;
  assign cand  = pend_q & ~block_q;
  assign take  = (state_q == IDLE) && ie_q && (|cand);

  assign iseret     = (inst[5:0] == 6'b010000);
  assign exregwrite = enable && !take && (sel != 2'd3);
  assign hasexp     = hasexp_q;
  assign expblock   = |(pend_q & block_q);

  // Lowest set index wins: scan downward so the last hit is the smallest.
  always_comb begin
    idx = '0;
    for (int unsigned i = NUM_SRC; i > 0; i--) begin
      if (cand[i-1]) idx = 4'(i - 1);
    end
  end

  // Clear the taken bit first, then OR in new edges, so an edge arriving
  // together with its own take keeps the source pending.
  always_comb begin
    take_mask = take ? (NUM_SRC'(1) << idx) : '0;
    pend_d    = (pend_q & ~take_mask) | rise;
  end

  always_comb begin
    cause_rd                 = '0;
    cause_rd[3:0]            = cause_q;
    cause_rd[16 +: NUM_SRC]  = pend_q;
  end

  always_comb begin
    d_out = '0;
    case (sel)
      2'd0:    d_out = epc_q;
      2'd1:    d_out = {30'd0, pie_q, ie_q};
      2'd2:    d_out = 32'(block_q);
      default: d_out = cause_rd;
    endcase
  end

  assign pc_out = hasexp_q ? (VEC_BASE + 32'(cause_q) * 32'(VEC_STRIDE)) : epc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      epc_q    <= '0;
      ie_q     <= 1'b0;
      pie_q    <= 1'b0;
      block_q  <= '0;
      pend_q   <= '0;
      exp_q    <= '0;
      cause_q  <= '0;
      hasexp_q <= 1'b0;
    end else begin
      exp_q    <= expsrc;
      pend_q   <= pend_d;
      hasexp_q <= take;
      if (take) begin
        epc_q   <= pc_in;
        cause_q <= idx;
        pie_q   <= ie_q;
        ie_q    <= 1'b0;
        state_q <= SERVICE;
      end else begin
        if (exregwrite) begin
          case (sel)
            2'd0: epc_q <= d_in;
            2'd1: begin
              ie_q  <= d_in[0];
              pie_q <= d_in[1];
            end
            2'd2:    block_q <= d_in[NUM_SRC-1:0];
            default: ;
          endcase
        end
        // Placed after the register write so eret's IE restore overrides a
        // simultaneous Status write, while PIE still takes the written value.
        if (state_q == SERVICE && iseret) begin
          ie_q    <= pie_q;
          state_q <= IDLE;
        end
      end
    end
  end

endmodule

// File: doc/cp0_vec.md
CP0_VEC -- requirements
Module: cp0_vec

Interface
REQ-001 Parameter NUM_SRC, default 8, number of exception sources (legal range 1..16).
REQ-002 Parameter VEC_BASE, default 32'h0000_0180, base address of the handler vector table.
REQ-003 Parameter VEC_STRIDE, default 8, byte distance between consecutive handler vectors.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 inst  in  32  current instruction; inst[12:11] selects the register; inst[5:0]==6'b010000 encodes eret.
REQ-007 pc_in  in  32  PC of the current instruction.
REQ-008 d_in  in  32  register write data.
REQ-009 expsrc  in  NUM_SRC  exception request lines, one per source.
REQ-010 enable  in  1  register write strobe.
REQ-011 exregwrite  out  1  write accepted this cycle.
REQ-012 iseret  out  1  inst decodes as eret.
REQ-013 hasexp  out  1  exception taken on the previous edge (one-cycle pulse).
REQ-014 expblock  out  1  at least one pending source is masked.
REQ-015 pc_out  out  32  redirect target.
REQ-016 d_out  out  32  register read data.

Function
REQ-017 Register select sel=inst[12:11] SHALL map as: 0=EPC, 1=Status, 2=Block, 3=Cause; d_out is a combinational read of the selected register, with unused bits read as 0.
REQ-018 Status SHALL use bit0=IE (global enable) and bit1=PIE (saved IE); Block[NUM_SRC-1:0] SHALL hold per-source masks; Cause[3:0] SHALL hold the last taken index and Cause[16+NUM_SRC-1:16] SHALL show the live pending bits.
REQ-019 The block SHALL register expsrc every cycle; a 0->1 transition on expsrc[i] SHALL set pend[i], which stays set until source i is taken, and a level held high SHALL NOT re-set pend[i].
REQ-020 FSM states SHALL be IDLE and SERVICE, with reset state IDLE.
REQ-021 take SHALL be defined as state==IDLE && IE && |(pend & ~Block); the winner SHALL be the lowest asserted index of pend & ~Block.
REQ-022 On a take edge: EPC<=pc_in, Cause[3:0]<=idx, pend[idx]<=0, PIE<=IE, IE<=0, state->SERVICE, hasexp<=1.
REQ-023 hasexp SHALL be high for exactly the one cycle after a take edge and low otherwise.
REQ-024 iseret SHALL be combinational: inst[5:0]==6'b010000, independent of state.
REQ-025 In SERVICE, an edge with iseret=1 SHALL set IE<=PIE and state->IDLE; iseret in IDLE SHALL change no state.
REQ-026 pc_out SHALL equal VEC_BASE + Cause[3:0]*VEC_STRIDE while hasexp=1, and EPC otherwise.
REQ-027 exregwrite SHALL equal enable && !take && sel!=3; when exregwrite=1, the edge writes: EPC<=d_in (sel 0), Status[1:0]<=d_in[1:0] (sel 1), Block<=d_in[NUM_SRC-1:0] (sel 2).
REQ-028 Simultaneous take and write: the take wins and the write SHALL be dropped.
REQ-029 Simultaneous eret and Status write in SERVICE: the eret update of IE SHALL win, and PIE takes d_in[1].
REQ-030 A new edge on an already-pending source SHALL be absorbed, with no counting.
REQ-031 A source edge coinciding with its own take SHALL leave pend set.
REQ-032 expblock SHALL equal |(pend & Block).
REQ-033 After eret, the earliest next take SHALL be the following edge.

Reset
REQ-034 While rst_n=0, asynchronously: EPC, Status, Block, Cause, pend and registered expsrc SHALL be 0, state SHALL be IDLE and hasexp SHALL be 0; with inst=0, outputs then read pc_out=0 and d_out=0.
REQ-035 A reset asserted in SERVICE SHALL return the block to IDLE with all pending requests discarded.

Verification
REQ-036 Enable IE, pulse expsrc[0] at pc_in=32'h1000_0000 -> next cycle hasexp=1, pc_out=32'h0000_0180, EPC=32'h1000_0000, IE=0, PIE=1.
REQ-037 IE=1, simultaneous edges on expsrc[5] and expsrc[2] -> source 2 is taken (pc_out=32'h0000_0190); after eret, source 5 is taken on the next edge (pc_out=32'h0000_01A8).
REQ-038 Block=8'h04, edge on expsrc[2] -> no take, expblock=1, Cause[18]=1; then write Block=0 -> take of source 2 on the following edge.
REQ-039 In SERVICE, issue inst[5:0]=6'b010000 -> iseret=1, pc_out=EPC, IE restored to 1, state IDLE.
REQ-040 Hold expsrc[1] high for 10 cycles with IE=1 -> exactly one take; a same-cycle enable write to EPC is dropped and exregwrite=0 on that take cycle.
REQ-041 Assert rst_n=0 mid-SERVICE with pend=8'h0A -> all registers read 0 immediately and no take occurs after release.
